// File: rtl/cache_pkg.sv
// Shared definitions for the data-cache sequencing controller.
//   ctrl_state_t     : controller FSM state encoding
//   CACHE_DATA_WIDTH : default word width
//   BE_WIDTH         : byte-enable width (one bit per byte of a word)
//   CNT_WIDTH        : width of the optional hit/miss statistics counters
package cache_pkg;

  localparam int CACHE_ADDR_WIDTH = 17;
  localparam int CACHE_DATA_WIDTH = 32;
  localparam int BE_WIDTH         = CACHE_DATA_WIDTH / 8;
  localparam int CNT_WIDTH        = 32;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_WAIT = 3'd1,
    FILL    = 3'd2,
    WT_WAIT = 3'd3,
    WT_DONE = 3'd4
  } ctrl_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter.
//   CLK   : clock
//   RST_N : asynchronous active-low reset, clears the count
//   en_i  : count one event this cycle
//   cnt_o : current count, holds at all-ones
module sat_counter
  import cache_pkg::*;
#(
  parameter int W = CNT_WIDTH
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)                     cnt_o <= '0;
    else if (en_i && (cnt_o != '1)) cnt_o <= cnt_o + W'(1);
  end

endmodule

// File: rtl/cache_ctrl.sv
// Sequencing controller for a direct-mapped, write-through, no-write-allocate
// data cache sitting between the CPU memory stage, the cache array and a
// multi-cycle data memory.
//
// Ports:
//   CLK, RST_N                 clock, asynchronous active-low reset
//   cpu_req_i/be_i/addr_i/wd_i CPU access (be==0 means read)
//   cpu_rd_o, stall_o          read data on completion, CPU hold
//   cache_hit_i, cache_rd_i    combinational array lookup for cache_addr_o
//   cache_addr_o               array address (CPU address in IDLE)
//   cache_wr_o                 byte-merge write into a hit line
//   cache_fill_o               whole-line fill (valid, new tag, data)
//   cache_wd_o, cache_be_o     array write data / byte enables
//   mem_req_o, mem_we_o        memory request, write flag
//   mem_addr_o/wd_o/be_o       memory request payload, held until ack
//   mem_ack_i, mem_rd_i        memory completion pulse and read data
//
// Optional feature, macro CACHE_CTRL_STATS_EN:
//   hit_cnt_o, miss_cnt_o      saturating per-access hit/miss counters
module cache_ctrl
  import cache_pkg::*;
#(
  parameter int ADDRESS_WIDTH = CACHE_ADDR_WIDTH,
  parameter int DATA_WIDTH    = CACHE_DATA_WIDTH
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     cpu_req_i,
  input  logic [BE_WIDTH-1:0]      cpu_be_i,
  input  logic [ADDRESS_WIDTH-1:0] cpu_addr_i,
  input  logic [DATA_WIDTH-1:0]    cpu_wd_i,
  output logic [DATA_WIDTH-1:0]    cpu_rd_o,
  output logic                     stall_o,
  input  logic                     cache_hit_i,
  input  logic [DATA_WIDTH-1:0]    cache_rd_i,
  output logic [ADDRESS_WIDTH-1:0] cache_addr_o,
  output logic                     cache_wr_o,
  output logic                     cache_fill_o,
  output logic [DATA_WIDTH-1:0]    cache_wd_o,
  output logic [BE_WIDTH-1:0]      cache_be_o,
  output logic                     mem_req_o,
  output logic                     mem_we_o,
  output logic [ADDRESS_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0]    mem_wd_o,
  output logic [BE_WIDTH-1:0]      mem_be_o,
  input  logic                     mem_ack_i,
  input  logic [DATA_WIDTH-1:0]    mem_rd_i
`ifdef CACHE_CTRL_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0]     hit_cnt_o,
  output logic [CNT_WIDTH-1:0]     miss_cnt_o
`endif
);

  ctrl_state_t              state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0]    data_q;   // write data, or fetched read data
  logic [BE_WIDTH-1:0]      be_q;

  logic is_rd, rd_hit, start_seq;

  assign is_rd     = (cpu_be_i == '0);
  assign rd_hit    = (state_q == IDLE) && cpu_req_i && is_rd && cache_hit_i;
  // Anything leaving IDLE (read miss or any write) latches the request.
  assign start_seq = (state_q == IDLE) && cpu_req_i && !rd_hit;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      be_q    <= '0;
    end else begin
      state_q <= state_d;
      if (start_seq) begin
        addr_q <= cpu_addr_i;
        data_q <= cpu_wd_i;
        be_q   <= cpu_be_i;
      end else if ((state_q == RD_WAIT) && mem_ack_i) begin
        data_q <= mem_rd_i;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    stall_o      = 1'b0;
    cpu_rd_o     = '0;
    cache_addr_o = addr_q;
    cache_wr_o   = 1'b0;
    cache_fill_o = 1'b0;
    cache_wd_o   = '0;
    cache_be_o   = '0;
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    mem_addr_o   = '0;
    mem_wd_o     = '0;
    mem_be_o     = '0;
    unique case (state_q)
      IDLE: begin
        cache_addr_o = cpu_addr_i;
        if (cpu_req_i) begin
          if (is_rd) begin
            if (cache_hit_i) begin
              cpu_rd_o = cache_rd_i;
            end else begin
              stall_o = 1'b1;
              state_d = RD_WAIT;
            end
          end else begin
            // Write hit updates the array now; memory write follows.
            stall_o    = 1'b1;
            cache_wr_o = cache_hit_i;
            cache_wd_o = cpu_wd_i;
            cache_be_o = cpu_be_i;
            state_d    = WT_WAIT;
          end
        end
      end
      RD_WAIT: begin
        stall_o    = 1'b1;
        mem_req_o  = 1'b1;
        mem_addr_o = addr_q;
        if (mem_ack_i) state_d = FILL;
      end
      FILL: begin
        cache_fill_o = 1'b1;
        cache_wd_o   = data_q;
        cache_be_o   = '1;
        cpu_rd_o     = data_q;
        state_d      = IDLE;
      end
      WT_WAIT: begin
        stall_o    = 1'b1;
        mem_req_o  = 1'b1;
        mem_we_o   = 1'b1;
        mem_addr_o = addr_q;
        mem_wd_o   = data_q;
        mem_be_o   = be_q;
        if (mem_ack_i) state_d = WT_DONE;
      end
      WT_DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef CACHE_CTRL_STATS_EN
  // Writes are counted when they complete, so remember the hit seen in IDLE.
  logic                           wr_hit_q;
  logic [1:0]                     cnt_en;
  logic [1:0][CNT_WIDTH-1:0]      cnt_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)         wr_hit_q <= 1'b0;
    else if (start_seq) wr_hit_q <= cache_hit_i;
  end

  assign cnt_en[0] = rd_hit || ((state_q == WT_DONE) && wr_hit_q);
  assign cnt_en[1] = (state_q == FILL) || ((state_q == WT_DONE) && !wr_hit_q);

  for (genvar g = 0; g < 2; g++) begin : g_cnt
    sat_counter #(.W(CNT_WIDTH)) u_cnt (
      .CLK   (CLK),
      .RST_N (RST_N),
      .en_i  (cnt_en[g]),
      .cnt_o (cnt_q[g])
    );
  end

  assign hit_cnt_o  = cnt_q[0];
  assign miss_cnt_o = cnt_q[1];
`endif

endmodule

// File: tb/tb_cache_ctrl.sv
// Randomized self-checking bench for cache_ctrl. The bench plays CPU, cache
// array (16 direct-mapped word lines) and a memory with random ack latency;
// expected read data comes from a word-level reference memory updated with
// byte-merged writes at issue time.
module tb_cache_ctrl;
  localparam int AW = 17;
  localparam int DW = 32;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          cpu_req_i;
  logic [3:0]    cpu_be_i;
  logic [AW-1:0] cpu_addr_i;
  logic [DW-1:0] cpu_wd_i;
  logic [DW-1:0] cpu_rd_o;
  logic          stall_o;
  logic          cache_hit_i;
  logic [DW-1:0] cache_rd_i;
  logic [AW-1:0] cache_addr_o;
  logic          cache_wr_o, cache_fill_o;
  logic [DW-1:0] cache_wd_o;
  logic [3:0]    cache_be_o;
  logic          mem_req_o, mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wd_o;
  logic [3:0]    mem_be_o;
  logic          mem_ack_i;
  logic [DW-1:0] mem_rd_i;
`ifdef CACHE_CTRL_STATS_EN
  logic [31:0]   hit_cnt_o, miss_cnt_o;
`endif

  cache_ctrl dut (
    .CLK(CLK), .RST_N(RST_N),
    .cpu_req_i(cpu_req_i), .cpu_be_i(cpu_be_i), .cpu_addr_i(cpu_addr_i),
    .cpu_wd_i(cpu_wd_i), .cpu_rd_o(cpu_rd_o), .stall_o(stall_o),
    .cache_hit_i(cache_hit_i), .cache_rd_i(cache_rd_i),
    .cache_addr_o(cache_addr_o), .cache_wr_o(cache_wr_o),
    .cache_fill_o(cache_fill_o), .cache_wd_o(cache_wd_o), .cache_be_o(cache_be_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wd_o(mem_wd_o), .mem_be_o(mem_be_o), .mem_ack_i(mem_ack_i),
    .mem_rd_i(mem_rd_i)
`ifdef CACHE_CTRL_STATS_EN
    , .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
`endif
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_init(input int w);
    return (32'(w) * 32'h9E3779B1) ^ 32'hC0FFEE00;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // ---------------- cache array model ----------------
  logic        lv   [16];
  logic [10:0] ltag [16];
  logic [31:0] ldat [16];
  logic [3:0]  ci;
  assign ci = cache_addr_o[5:2];

  always_comb begin
    cache_hit_i = lv[ci] && (ltag[ci] == cache_addr_o[16:6]);
    cache_rd_i  = cache_hit_i ? ldat[ci] : 32'hBAD0BAD0;
  end

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < 16; i++) lv[i] <= 1'b0;
    end else begin
      if (cache_fill_o) begin
        lv[ci]   <= 1'b1;
        ltag[ci] <= cache_addr_o[16:6];
        ldat[ci] <= cache_wd_o;
      end
      if (cache_wr_o) ldat[ci] <= merge(ldat[ci], cache_wd_o, cache_be_o);
    end
  end

  // ---------------- memory model ----------------
  logic [31:0] mem_env [int];
  logic [31:0] ref_mem [int];
  logic          exp_we;
  logic [AW-1:0] exp_maddr;
  logic [31:0]   exp_mwd;
  logic [3:0]    exp_mbe;
  int  last_delay = 0;
  bit  hold_ack = 0, force_spur = 0, spur_en = 1;

  initial begin
    int  mcnt, mdelay, w;
    bit  busy, prev_ack;
    mem_ack_i = 1'b0; mem_rd_i = '0; busy = 0; prev_ack = 0; mcnt = 0; mdelay = 0;
    forever begin
      @(posedge CLK); #1;
      mem_ack_i = 1'b0; mem_rd_i = '0;
      if (!RST_N) begin busy = 0; prev_ack = 0; continue; end
      if (prev_ack) chk("req_drop_after_ack", 64'(mem_req_o), 64'(0));
      prev_ack = 0;
      if (mem_req_o) begin
        if (!busy) begin
          busy = 1; mcnt = 0; mdelay = $urandom_range(0, 3); last_delay = mdelay;
        end
        chk("mem_we", 64'(mem_we_o), 64'(exp_we));
        chk("mem_addr", 64'(mem_addr_o), 64'(exp_maddr));
        if (exp_we) begin
          chk("mem_wd", 64'(mem_wd_o), 64'(exp_mwd));
          chk("mem_be", 64'(mem_be_o), 64'(exp_mbe));
        end
        if (!hold_ack && mcnt == mdelay) begin
          w = int'(mem_addr_o[AW-1:2]);
          if (mem_we_o)
            mem_env[w] = merge(mem_env.exists(w) ? mem_env[w] : mem_init(w), mem_wd_o, mem_be_o);
          else
            mem_rd_i = mem_env.exists(w) ? mem_env[w] : mem_init(w);
          mem_ack_i = 1'b1; busy = 0; prev_ack = 1;
        end else begin
          mcnt++;
        end
      end else if (force_spur || (spur_en && $urandom_range(0, 7) == 0)) begin
        mem_ack_i = 1'b1; mem_rd_i = $urandom;  // must be ignored
      end
    end
  end

  // ---------------- CPU driver / checker ----------------
  int exp_hits = 0, exp_miss = 0;

  task automatic access(input logic [3:0] be, input logic [AW-1:0] addr, input logic [31:0] wd);
    int w;
    bit ehit, done, saw_wr, saw_fill;
    logic [31:0] expd;
    w    = int'(addr[AW-1:2]);
    ehit = lv[addr[5:2]] && (ltag[addr[5:2]] == addr[16:6]);
    expd = ref_mem.exists(w) ? ref_mem[w] : mem_init(w);
    if (be != 0) ref_mem[w] = merge(expd, wd, be);
    if (ehit) exp_hits++; else exp_miss++;
    exp_we = (be != 0); exp_maddr = addr; exp_mwd = wd; exp_mbe = be;
    cpu_req_i = 1'b1; cpu_be_i = be; cpu_addr_i = addr; cpu_wd_i = wd;
    done = 0; saw_wr = 0; saw_fill = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge CLK);
      if (c == 0) begin
        chk("cache_addr", 64'(cache_addr_o), 64'(addr));
        chk("cache_wr", 64'(cache_wr_o), 64'((be != 0) && ehit));
        if (cache_wr_o) begin
          chk("cache_wd", 64'(cache_wd_o), 64'(wd));
          chk("cache_be", 64'(cache_be_o), 64'(be));
        end
      end else if (cache_wr_o) saw_wr = 1;
      if ((be != 0) && cache_fill_o) saw_fill = 1;
      if (!stall_o) begin
        done = 1;
        if (be == 0) begin
          chk("rd_data", 64'(cpu_rd_o), 64'(expd));
          if (ehit) chk("rd_hit_lat", 64'(c), 64'(0));
          else begin
            chk("rd_miss_lat", 64'(c), 64'(last_delay + 2));
            chk("fill", 64'(cache_fill_o), 64'(1));
            chk("fill_wd", 64'(cache_wd_o), 64'(expd));
            chk("fill_addr", 64'(cache_addr_o), 64'(addr));
          end
        end else begin
          chk("wr_lat", 64'(c), 64'(last_delay + 2));
          chk("wr_rd0", 64'(cpu_rd_o), 64'(0));
        end
      end
      @(posedge CLK); #1;
      if (!done && $urandom_range(0, 3) == 0) cpu_req_i = 1'b0;  // drop must be ignored
    end
    chk("no_timeout", 64'(done), 64'(1));
    if (be != 0) begin
      chk("wr_no_late_wr", 64'(saw_wr), 64'(0));
      chk("wr_no_fill", 64'(saw_fill), 64'(0));
    end
    cpu_req_i = 1'b0;
  endtask

  task automatic idle_cycle();
    cpu_req_i = 1'b0; cpu_be_i = 4'($urandom); cpu_addr_i = AW'($urandom);
    @(negedge CLK);
    chk("idle_stall", 64'(stall_o), 64'(0));
    chk("idle_strb", 64'({cache_wr_o, cache_fill_o, mem_req_o}), 64'(0));
    chk("idle_rd", 64'(cpu_rd_o), 64'(0));
    @(posedge CLK); #1;
  endtask

  initial begin
    logic [AW-1:0] a;
    logic [3:0]    be;
    cpu_req_i = 1'b0; cpu_be_i = '0; cpu_addr_i = '0; cpu_wd_i = '0;
    exp_we = 1'b0; exp_maddr = '0; exp_mwd = '0; exp_mbe = '0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_stall", 64'(stall_o), 64'(0));
    chk("rst_strb", 64'({cache_wr_o, cache_fill_o, mem_req_o, mem_we_o}), 64'(0));
    chk("rst_mem_pay", 64'({mem_addr_o, mem_wd_o, mem_be_o}), 64'(0));
    chk("rst_rd", 64'(cpu_rd_o), 64'(0));
    @(posedge CLK); #1 RST_N = 1'b1;

    // reset while waiting for a read miss
    hold_ack = 1; spur_en = 0;
    exp_we = 1'b0; exp_maddr = 17'h100;
    cpu_be_i = 4'h0; cpu_addr_i = 17'h100; cpu_req_i = 1'b1;
    @(negedge CLK); chk("rmiss_stall", 64'(stall_o), 64'(1));
    @(posedge CLK); #1 cpu_req_i = 1'b0;
    @(negedge CLK); chk("rd_wait_req", 64'(mem_req_o), 64'(1));
    RST_N = 1'b0; #1;
    chk("rst_async_req", 64'(mem_req_o), 64'(0));
    chk("rst_async_fill", 64'(cache_fill_o), 64'(0));
    chk("rst_async_stall", 64'(stall_o), 64'(0));
    @(posedge CLK); #2 RST_N = 1'b1;
    hold_ack = 0; force_spur = 1;
    repeat (4) idle_cycle();
    force_spur = 0; spur_en = 1;
    chk("rst_no_line", 64'(lv[0]), 64'(0));

    // directed: write miss, read miss, read hit, write hit, merged read hit
    access(4'hF, 17'h0040, 32'hDEADBEEF);
    access(4'h0, 17'h0040, 32'h0);
    access(4'h0, 17'h0040, 32'h0);
    access(4'b0011, 17'h0040, 32'hAABBCCDD);
    access(4'h0, 17'h0040, 32'h0);

    // random traffic over a small address space so lines collide
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 9) == 0) a = AW'($urandom) & ~AW'(3);
      else a = AW'($urandom_range(0, 63) << 2);
      be = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      access(be, a, $urandom);
      if ($urandom_range(0, 4) == 0) idle_cycle();
    end

`ifdef CACHE_CTRL_STATS_EN
    @(negedge CLK);
    chk("hit_cnt", 64'(hit_cnt_o), 64'(exp_hits));
    chk("miss_cnt", 64'(miss_cnt_o), 64'(exp_miss));
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cache_ctrl.md
# cache_ctrl

Sequencing controller for the direct-mapped, write-through data cache: it sits between the CPU memory stage, the cache array and the multi-cycle data memory. On a read hit it answers in the same cycle. On a read miss it stalls the CPU, fetches the word from memory and fills the line. On every write it updates the array on a hit, writes through to memory (no-allocate on miss) and holds the stall until memory acknowledges.

## Interface
- ADDRESS_WIDTH, 17, byte address width
- DATA_WIDTH, 32, word width; byte-enable width is DATA_WIDTH/8
- CLK  input  1  clock; all state updates on the rising edge
- RST_N  input  1  reset; asynchronous, active-low
- cpu_req_i  input  1  CPU memory-stage access valid
- cpu_be_i  input  4  byte write enables; 0 means read
- cpu_addr_i  input  ADDRESS_WIDTH  byte address
- cpu_wd_i  input  DATA_WIDTH  write data
- cpu_rd_o  output  DATA_WIDTH  read data, valid when the access completes
- stall_o  output  1  CPU must hold its request
- cache_hit_i  input  1  combinational hit from the array for cache_addr_o
- cache_rd_i  input  DATA_WIDTH  array read data
- cache_addr_o  output  ADDRESS_WIDTH  array address
- cache_wr_o  output  1  byte-merge write of cache_wd_o/cache_be_o into a hit line
- cache_fill_o  output  1  whole-line fill: valid=1, new tag, cache_wd_o
- cache_wd_o  output  DATA_WIDTH  array write data
- cache_be_o  output  4  array byte enables
- mem_req_o, mem_we_o  output  1 each  memory request and write flag
- mem_addr_o, mem_wd_o, mem_be_o  output  ADDRESS_WIDTH, DATA_WIDTH, 4  memory request payload
- mem_ack_i  input  1  memory completion, single-cycle pulse
- mem_rd_i  input  DATA_WIDTH  memory read data, valid with mem_ack_i

## Operation
- States: IDLE, RD_WAIT, FILL, WT_WAIT, WT_DONE.
- Completion rule: a cycle with cpu_req_i=1 and stall_o=0 completes the access. The CPU advances at the next edge.
- IDLE, no request: all strobes 0, stall_o=0.
- IDLE, read hit: cpu_rd_o=cache_rd_i, stall_o=0, stay in IDLE.
- IDLE, read miss:
  - stall_o=1.
  - Latch address into addr_q.
  - Go to RD_WAIT.
- IDLE, write:
  - stall_o=1.
  - Latch addr/data/be.
  - If cache_hit_i, pulse cache_wr_o this cycle (array updated at this edge).
  - Go to WT_WAIT.
- RD_WAIT:
  - mem_req_o=1, mem_we_o=0, mem_addr_o=addr_q, stall_o=1.
  - On mem_ack_i, capture mem_rd_i into data_q and go to FILL.
- FILL:
  - cache_fill_o=1, cache_addr_o=addr_q, cache_wd_o=data_q.
  - cpu_rd_o=data_q, stall_o=0 (read completes).
  - Go to IDLE.
- WT_WAIT:
  - mem_req_o=1, mem_we_o=1, latched payload, stall_o=1.
  - On mem_ack_i, go to WT_DONE.
- WT_DONE: stall_o=0 (write completes), no strobes, go to IDLE.
- cache_addr_o = cpu_addr_i in IDLE, addr_q otherwise. cpu_rd_o = 0 whenever no read completes.

## Timing
- Read hit: 0-cycle latency.
- Read miss: stalled for (ack cycle − request cycle + 1) cycles, then 1 FILL cycle. With immediate ack: 2 stalled cycles, completion on cycle 3.
- Write: minimum 3 cycles (IDLE, WT_WAIT with ack, WT_DONE).
- mem_req_o and its payload are stable from assertion until the ack cycle inclusive. mem_req_o deasserts the cycle after ack.
- mem_ack_i outside RD_WAIT/WT_WAIT is ignored.
- cpu_req_i dropping while not in IDLE is ignored; the sequence finishes.
- Reset (asynchronous, any state):
  - State goes to IDLE; addr_q, data_q and be_q clear to 0.
  - mem_req_o, cache_wr_o and cache_fill_o drop immediately.
  - The in-flight transaction is abandoned with no fill.
- Reset values of all outputs: 0, except the combinational stall_o/cpu_rd_o derived in IDLE.

## Configuration
- CACHE_CTRL_STATS_EN defined: adds outputs hit_cnt_o and miss_cnt_o, each 32 bits.
  - Counted once per completed access: hit on IDLE read hit or write hit, miss on FILL or write miss.
  - Counters saturate at all-ones and clear on reset.
- Undefined: the ports and counters do not exist; behaviour is otherwise identical.

## Structure
- cache_pkg holds:
  - The ctrl_state_t enum.
  - BE_WIDTH = DATA_WIDTH/8.
  - The counter width constant.
- Sub-module sat_counter (enable, clear-on-reset, saturating) is instantiated twice under CACHE_CTRL_STATS_EN.

## Test plan
- Reset then read hit: cache_hit_i=1, cache_rd_i=32'hDEADBEEF → cpu_rd_o=32'hDEADBEEF, stall_o=0 in the same cycle.
- Read miss, ack after 3 cycles with mem_rd_i=32'h12345678 → stall high 4 cycles; FILL cycle has cache_fill_o=1, cpu_rd_o=32'h12345678.
- Write hit, be=4'b0011, wd=32'hAABBCCDD → cache_wr_o pulse in IDLE; mem_we_o=1 with identical payload until ack; stall low only in WT_DONE.
- Write miss → cache_wr_o and cache_fill_o never assert; memory write still issued.
- RST_N low during RD_WAIT → mem_req_o 0 immediately; a later mem_ack_i is ignored; no fill occurs.
- With CACHE_CTRL_STATS_EN: 5 hits, 2 read misses, 1 write miss → hit_cnt_o=5, miss_cnt_o=3. Forced near saturation, hit_cnt_o holds 32'hFFFFFFFF.
